// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the ROM fetch master
package fetch_pkg;

  localparam int FETCH_AW = 16;
  localparam int FETCH_DW = 16;

  localparam logic [FETCH_DW-1:0] ERR_WORD_DEFAULT = '0;

  typedef enum logic [1:0] {
    IDLE,
    CS_HOLD,
    WAIT_DATA
  } fetch_state_t;

endpackage

// File: rtl/rom_fetch_master_if.sv
// rtl/rom_fetch_master_if.sv - core fetch port and ROM cs/address handshake bundle
interface rom_fetch_master_if;
  import fetch_pkg::*;

  // core side
  logic                req;
  logic [FETCH_AW-1:0] req_addr;
  logic                req_ready;
  logic                rsp_valid;
  logic [FETCH_DW-1:0] rsp_data;
  logic                rsp_err;

  // ROM side
  logic                cs;
  logic [FETCH_AW-1:0] address;
  logic                ready;
  logic [FETCH_DW-1:0] data;

  modport master (
    input  req, req_addr, ready, data,
    output req_ready, rsp_valid, rsp_data, rsp_err, cs, address
  );

  modport slave (
    output req, req_addr, ready, data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, cs, address
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - clearable up-counter flagging the fetch abort point
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;

  // count cycles spent on a fetch; clear wins so each fetch starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + W'(1);
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/rom_fetch_master.sv
// rtl/rom_fetch_master.sv - single-outstanding fetch initiator for the 16-bit instruction ROM
module rom_fetch_master
  import fetch_pkg::*;
#(
  parameter int                  TIMEOUT  = 16,
  parameter logic [FETCH_DW-1:0] ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_fetch_master_if.master  bus
);

  fetch_state_t        state_q, state_d;
  logic                cs_q, cs_d;
  logic [FETCH_AW-1:0] addr_q, addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [FETCH_DW-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                ctr_tc;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .en    (state_q != IDLE),
    .tc    (ctr_tc)
  );

  // state and all bus-facing registers; reset pulls cs low immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // handshake sequencing: accept, wait for ROM ack, wait for data, or abort
  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    addr_d      = addr_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.req_addr;
          cs_d    = 1'b1;
          state_d = CS_HOLD;
        end
      end
      CS_HOLD: begin
        // ready high here is only the ROM idle level, never data
        if (ctr_tc) begin
          cs_d        = 1'b0;
          rsp_data_d  = ERR_WORD;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (!bus.ready) begin
          cs_d    = 1'b0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        // data arriving on the terminal-count edge still completes normally
        if (bus.ready) begin
          rsp_data_d  = bus.data;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (ctr_tc) begin
          cs_d        = 1'b0;
          rsp_data_d  = ERR_WORD;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        cs_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.cs        = cs_q;
  assign bus.address   = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rom_fetch_master.sv
// tb/tb_rom_fetch_master.sv - scoreboard bench for rom_fetch_master against a 3-state ROM model
module tb_rom_fetch_master;
  import fetch_pkg::*;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cs_total = 0;
  exp_t sb[$];

  // ROM model controls
  int   ack_len = 1;
  logic hang = 1'b0;
  logic no_ack = 1'b0;
  logic [1:0]  rom_st;
  int          ack_cnt;
  logic        rom_ready;
  logic [15:0] rom_data;

  rom_fetch_master_if bus();

  rom_fetch_master #(.TIMEOUT(TIMEOUT), .ERR_WORD(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // free-running cycle count used to time responses
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0123: return 16'hBEEF;
      16'h0000: return 16'h1A2B;
      16'h0001: return 16'h3C4D;
      16'h0002: return 16'h5E6F;
      16'h0003: return 16'h7081;
      default:  return ~a;
    endcase
  endfunction

  // ROM: idle (ready=1) -> ack (ready=0 for ack_len cycles) -> data (ready=1) -> idle on cs low
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_st    <= 2'd0;
      rom_ready <= 1'b1;
      rom_data  <= 16'h0000;
      ack_cnt   <= 0;
    end else begin
      case (rom_st)
        2'd0: if (bus.cs && !no_ack) begin
          rom_st    <= 2'd1;
          rom_ready <= 1'b0;
          ack_cnt   <= 0;
        end
        2'd1: if (!hang && (ack_cnt + 1 >= ack_len)) begin
          rom_st    <= 2'd2;
          rom_ready <= 1'b1;
          rom_data  <= rom_word(bus.address);
        end else begin
          ack_cnt <= ack_cnt + 1;
        end
        default: if (!bus.cs) rom_st <= 2'd0;
      endcase
    end
  end

  assign bus.ready = no_ack ? 1'b1 : rom_ready;
  assign bus.data  = rom_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pop the scoreboard on every response strobe and compare
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.cs) cs_total++;
      if (bus.rsp_valid) begin
        check("rsp_cs_low", 32'(bus.cs), 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data %0h err %0b expected no response", bus.rsp_data, bus.rsp_err);
        end else begin
          e = sb.pop_front();
          check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // issue one request at a negedge; lat is the cycle offset from the accepting negedge to the response
  task automatic fetch(input logic [15:0] a, input logic [15:0] d, input logic e, input int lat, output int acc);
    int w = 0;
    bus.req      = 1'b1;
    bus.req_addr = a;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    acc = cyc;
    if (!bus.req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_wait: got req_ready 0 expected 1 within 100 cycles");
    end else begin
      sb.push_back('{data: d, err: e, cyc: cyc + lat});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc, prev, c0;
    bus.req      = 1'b0;
    bus.req_addr = 16'h0000;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_cs", 32'(bus.cs), 32'd0);
    check("rst_address", 32'(bus.address), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // nominal fetch of 0x0123
    c0 = cs_total;
    fetch(16'h0123, 16'hBEEF, 1'b0, 4, acc);
    bus.req = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check("cs_width", 32'(cs_total - c0), 32'd2);
    check("hold_data", 32'(bus.rsp_data), 32'hBEEF);
    check("hold_valid_low", 32'(bus.rsp_valid), 32'd0);

    // back-to-back with req held high
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      fetch(16'(i), rom_word(16'(i)), 1'b0, 4, acc);
      if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd4);
      prev = acc;
    end
    bus.req = 1'b0;
    drain();

    // ready stuck high: never acknowledged
    no_ack = 1'b1;
    fetch(16'h0010, 16'h0000, 1'b1, TIMEOUT + 1, acc);
    bus.req = 1'b0;
    drain();
    check("stuck1_cs", 32'(bus.cs), 32'd0);
    no_ack = 1'b0;
    repeat (2) @(negedge clk);

    // ready stuck low after acknowledge, then a normal fetch
    hang = 1'b1;
    fetch(16'h0002, 16'h0000, 1'b1, TIMEOUT + 1, acc);
    bus.req = 1'b0;
    drain();
    hang = 1'b0;
    repeat (3) @(negedge clk);
    fetch(16'h0003, 16'h7081, 1'b0, 4, acc);
    bus.req = 1'b0;
    drain();

    // delayed data: ready low 3 cycles
    ack_len = 3;
    c0 = cs_total;
    fetch(16'h0001, 16'h3C4D, 1'b0, 6, acc);
    bus.req = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check("delay_cs_width", 32'(cs_total - c0), 32'd2);

    // data arriving on the terminal-count edge wins; one cycle later it loses
    ack_len = TIMEOUT - 2;
    fetch(16'h0123, 16'hBEEF, 1'b0, TIMEOUT + 1, acc);
    bus.req = 1'b0;
    drain();
    ack_len = TIMEOUT - 1;
    fetch(16'h0000, 16'h0000, 1'b1, TIMEOUT + 1, acc);
    bus.req = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // reset while waiting for data
    ack_len = 3;
    fetch(16'h0123, 16'hBEEF, 1'b0, 6, acc);
    bus.req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs", 32'(bus.cs), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ack_len = 1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_address", 32'(bus.address), 32'd0);
    repeat (10) @(negedge clk);
    fetch(16'h0002, 16'h5E6F, 1'b0, 4, acc);
    bus.req = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/rom_fetch_master.md
# rom_fetch_master

Bus initiator that drives the 16-bit instruction ROM's `cs`/`address` handshake on behalf of the processor core. It accepts one fetch request at a time from the core, runs the chip-select / ready handshake against the ROM, registers the returned word, and presents it to the core as a one-cycle response. A watchdog aborts a fetch if the ROM stops responding. It sits between the core's fetch stage and the ROM slave.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles a fetch may spend in `CS_HOLD`+`WAIT_DATA` before abort; must be ≥4.
- `ERR_WORD`, default 16'h0000: data returned on timeout.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  core fetch request.
- `req_addr`  in  16  fetch address; sampled with `req`.
- `req_ready`  out  1  high when a request will be accepted this cycle.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_data`  out  16  fetched word; valid with `rsp_valid`.
- `rsp_err`  out  1  timeout flag; valid with `rsp_valid`.
- `cs`  out  1  ROM chip select.
- `address`  out  16  ROM address.
- `ready`  in  1  ROM ready; idle-high, drops low to acknowledge, rises with data valid.
- `data`  in  16  ROM read data; meaningful only while `ready` is high after an acknowledge.

## Operation
- States: `IDLE`, `CS_HOLD`, `WAIT_DATA`.
- `IDLE`: `req_ready`=1, `cs`=0. If `req` is high, latch `req_addr` into `address`, set `cs`=1, and clear the timeout counter. Next state is `CS_HOLD`.
- `CS_HOLD`: `cs`=1, `address` held.
  - If `ready` is sampled 0 (ROM acknowledge): `cs`←0 and go to `WAIT_DATA`.
  - A high `ready` here is the ROM's idle level. It is ignored and never treated as data.
- `WAIT_DATA`: `cs`=0, `address` held.
  - If `ready` is sampled 1: `rsp_data`←`data`, `rsp_err`←0, pulse `rsp_valid`, go to `IDLE`.
- Timeout: the counter increments every cycle in `CS_HOLD` or `WAIT_DATA`. When it reaches `TIMEOUT`-1 without completion: `cs`←0, `rsp_data`←`ERR_WORD`, `rsp_err`←1, pulse `rsp_valid`, go to `IDLE`.
- One outstanding fetch only. `req` outside `IDLE` is ignored; the core must hold `req` until it sees `req_ready`.
- `cs` is dropped immediately after the acknowledge so the ROM returns to idle and does not start a second access.
- `rsp_data` and `rsp_err` hold their last values between strobes.

## Timing
- Reset (asynchronous assert, synchronous release): state=`IDLE`, `cs`=0, `address`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, counter=0. `req_ready`=1 once reset is released.
- Nominal fetch, with E0 the edge that samples `req`:
  - E0: `cs` goes high.
  - E1: ROM samples `cs`; `ready` falls.
  - E2: master sees `ready`=0 and drops `cs`; ROM moves to its data state.
  - E3: master captures `data`; `rsp_valid` is high during the E3–E4 cycle.
  - Latency from request to response is 4 cycles.
- `req_ready` is high again after E3. Back-to-back requests are therefore accepted every 4 cycles.
- `rsp_valid` is exactly one cycle wide and never asserts in the same cycle as `cs`.
- Reset mid-fetch: `cs` drops asynchronously and no `rsp_valid` is issued.
- Timeout and data arriving on the same edge: data wins, `rsp_err`=0.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` (`IDLE`, `CS_HOLD`, `WAIT_DATA`);
  - `FETCH_AW`=16, `FETCH_DW`=16;
  - default `ERR_WORD`.
- One sub-module, `fetch_timeout_ctr`: a clearable up-counter with terminal-count output, width $clog2(`TIMEOUT`). Used by the FSM for abort.

## Test plan
- ROM model with 3-state behaviour, word at 0x0123 = 16'hBEEF. Request 0x0123 → `cs` high for exactly 2 cycles; `rsp_valid` 4 cycles after acceptance with `rsp_data`=16'hBEEF, `rsp_err`=0.
- Hold `req` high continuously over addresses 0x0000..0x0003 → 4 responses spaced every 4 cycles, in order, each with the correct data.
- Hold `ready` stuck at 1 → `rsp_valid` after `TIMEOUT` cycles with `rsp_data`=16'h0000, `rsp_err`=1, `cs`=0.
- Hold `ready` stuck at 0 after the acknowledge → timeout response; the next request then completes normally.
- Assert `rst_n`=0 in `WAIT_DATA` → `cs`=0 and `rsp_valid`=0 immediately; after release, `req_ready`=1 and no stale response appears.
- ROM delays its data: `ready` low for 3 cycles before rising → response is delayed by 2 cycles, data is correct, `cs` is never re-asserted while waiting.
